ex_muldiv_unit: RTL

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the register-file operands and decoded MULT/MULTU/DIV/DIVU commands that ID/EX presents, computes 64-bit results one bit per cycle, and holds them in architectural HI/LO registers. It also generates the stall that freezes IF/ID/EX while an EX instruction needs the unit and the unit is busy.

---
 rtl/ex_muldiv_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: owns HI/LO and raises the pipeline stall.
// Optional feature macro MULDIV_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier is zero.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    input  logic             read_req,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_next;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rs_save;
    logic [CW-1:0]      count;
    logic               is_div, neg_q, neg_r, div_zero;

    logic               signed_op, rs_neg, rt_neg, rt_zero, accept;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign signed_op = ~op[0];
    assign rs_neg    = signed_op & rs_data[WIDTH-1];
    assign rt_neg    = signed_op & rt_data[WIDTH-1];
    assign rs_abs    = rs_neg ? -rs_data : rs_data;
    assign rt_abs    = rt_neg ? -rt_data : rt_data;
    assign rt_zero   = (rt_data == '0);
    assign accept    = start & ~flush & (state == IDLE);

    assign busy  = (state != IDLE);
    assign stall = busy & (start | read_req | hi_we | lo_we);

    // Divide keeps {remainder, dividend/quotient} in acc and the divisor in mplier.
    assign mul_next  = acc + (mplier[0] ? mcand : '0);
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, mplier};
    assign rem_next  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign div_next  = {rem_next, acc[WIDTH-2:0], ~div_diff[WIDTH]};

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op[1] && rt_zero)
                        state_next = FIX;
`ifdef MULDIV_EARLY_OUT_EN
                    else if (!op[1] && rt_zero)
                        state_next = FIX;
`endif
                    else
                        state_next = CALC;
                end
            end
            CALC: begin
                if (count == '0)
                    state_next = FIX;
`ifdef MULDIV_EARLY_OUT_EN
                else if (!is_div && (mplier[WIDTH-1:1] == '0))
                    state_next = FIX;
`endif
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rs_save  <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we)
                        hi <= wdata;
                    if (lo_we)
                        lo <= wdata;
                    if (accept) begin
                        is_div   <= op[1];
                        neg_q    <= rs_neg ^ rt_neg;
                        neg_r    <= rs_neg;
                        div_zero <= op[1] & rt_zero;
                        rs_save  <= rs_data;
                        count    <= CW'(WIDTH - 1);
                        mplier   <= rt_abs;
                        if (op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, rs_abs};
                            mcand <= '0;
                        end else begin
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, rs_abs};
                        end
                    end
                end
                CALC: begin
                    count <= count - CW'(1);
                    if (is_div) begin
                        acc <= div_next;
                    end else begin
                        acc    <= mul_next;
                        mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                        mplier <= {1'b0, mplier[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    // A flush in the FIX cycle squashes the write-back entirely.
                    if (!flush) begin
                        done <= 1'b1;
                        if (div_zero) begin
                            hi <= rs_save;
                            lo <= '1;
                        end else if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
